// File: rtl/pipeline_run_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_run_ctrl
//   Run/halt/single-step/breakpoint sequencer for a five-stage pipeline. It
//   produces per-register advance enables and wrong-path flushes for the
//   IF/DE, DE/EXE, EXE/MEM and MEM/WB pipeline registers. It also keeps
//   advance and flush counters for debug and visualisation.
//
// Ports
//   i_clk          system clock, all state updates on the rising edge
//   i_reset        asynchronous active-high reset
//   i_halt         level stop request
//   i_resume       resume request (rising edge detected internally)
//   i_step         single-step request (rising edge detected internally)
//   i_bp_en        breakpoint enable
//   i_bp_addr      breakpoint PC
//   i_pc           current fetch PC
//   i_pc_src       taken branch / PC write signalled by writeback
//   o_stage_en     advance enables {MEM_WB, EXE_MEM, DE_EXE, IF_DE}
//   o_stage_flush  bubble insert   {EXE_MEM, DE_EXE, IF_DE}
//   o_state        RUN=00, HALTED=01, STEP=10
//   o_bp_hit       sticky breakpoint-stop indicator
//   o_adv_count    advancing cycles, wraps modulo 2^32
//   o_flush_count  flush events, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module pipeline_run_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_halt,
   input  logic             i_resume,
   input  logic             i_step,
   input  logic             i_bp_en,
   input  logic [WIDTH-1:0] i_bp_addr,
   input  logic [WIDTH-1:0] i_pc,
   input  logic             i_pc_src,
   output logic [3:0]       o_stage_en,
   output logic [2:0]       o_stage_flush,
   output logic [1:0]       o_state,
   output logic             o_bp_hit,
   output logic [31:0]      o_adv_count,
   output logic [15:0]      o_flush_count
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_HALTED = 2'b01,
      ST_STEP   = 2'b10
   } state_t;

   state_t      r_state;
   state_t      w_nxt_state;
   logic        r_bp_hit;
   logic        r_bp_mask;
   logic        r_step_q;
   logic        r_resume_q;
   logic [31:0] r_adv_count;
   logic [15:0] r_flush_count;

   logic        w_step_p;
   logic        w_resume_p;
   logic        w_adv;
   logic        w_flush;
   logic        w_match;
   logic        w_nxt_bp_hit;
   logic        w_nxt_bp_mask;

   // Saturating increment for the flush event counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      return (val == 16'hFFFF) ? val : val + 16'd1;
   endfunction

   assign w_step_p   = i_step & ~r_step_q;
   assign w_resume_p = i_resume & ~r_resume_q;
   assign w_adv      = (r_state == ST_RUN) || (r_state == ST_STEP);
   assign w_flush    = w_adv & i_pc_src;
   assign w_match    = i_bp_en & (i_pc == i_bp_addr) & ~r_bp_mask;

   // State is already RUN during reset, so the enables need an explicit mask
   // while reset is held; after release they come straight from the state.
   assign o_stage_en    = {4{w_adv & ~i_reset}};
   assign o_stage_flush = {3{w_flush & ~i_reset}};
   assign o_state       = r_state;
   assign o_bp_hit      = r_bp_hit;
   assign o_adv_count   = r_adv_count;
   assign o_flush_count = r_flush_count;

   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_bp_hit  = r_bp_hit;
      w_nxt_bp_mask = r_bp_mask;
      case (r_state)
         ST_RUN: begin
            // The mask only covers the first RUN cycle after a resume.
            w_nxt_bp_mask = 1'b0;
            if (i_halt || w_match) begin
               w_nxt_state = ST_HALTED;
            end
            // A breakpoint coinciding with halt is still reported.
            if (w_match) begin
               w_nxt_bp_hit = 1'b1;
            end
         end
         ST_HALTED: begin
            if (w_step_p) begin
               w_nxt_state  = ST_STEP;
               w_nxt_bp_hit = 1'b0;
            end else if (w_resume_p && !i_halt) begin
               w_nxt_state   = ST_RUN;
               w_nxt_bp_hit  = 1'b0;
               w_nxt_bp_mask = 1'b1;
            end
         end
         ST_STEP: begin
            w_nxt_state = ST_HALTED;
         end
         default: begin
            w_nxt_state = ST_HALTED;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= ST_RUN;
         r_bp_hit      <= 1'b0;
         r_bp_mask     <= 1'b0;
         r_step_q      <= 1'b0;
         r_resume_q    <= 1'b0;
         r_adv_count   <= 32'd0;
         r_flush_count <= 16'd0;
      end else begin
         r_state    <= w_nxt_state;
         r_bp_hit   <= w_nxt_bp_hit;
         r_bp_mask  <= w_nxt_bp_mask;
         r_step_q   <= i_step;
         r_resume_q <= i_resume;
         if (w_adv) begin
            r_adv_count <= r_adv_count + 32'd1;
         end
         if (w_flush) begin
            r_flush_count <= sat_inc16(r_flush_count);
         end
      end
   end

endmodule
